// File: rtl/instr_mem_pipe.sv
// Instruction memory for the fetch stage: valid/ready request/response handshake,
// a READ_LATENCY-deep registered read pipe, load port, fault flags, flush and a fetch counter.
module instr_mem_pipe #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH_WORDS  = 256,
    parameter int unsigned     READ_LATENCY = 1,
    parameter logic [XLEN-1:0] NOP_WORD     = 32'h00000013,
    localparam int unsigned    AW           = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic [XLEN-1:0] rsp_pc,
    output logic [1:0]      rsp_fault,
    input  logic            ld_we,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic [31:0]     fetch_count
);
    localparam int unsigned LAT = READ_LATENCY;

    // Power-up image is all NOPs; contents survive reset.
    logic [XLEN-1:0] r_mem [DEPTH_WORDS] = '{default: NOP_WORD};

    logic [LAT:1]    r_vld_pipe;
    logic [XLEN-1:0] r_pc_pipe    [LAT:1];
    logic [XLEN-1:0] r_instr_pipe [LAT:1];
    logic [1:0]      r_fault_pipe [LAT:1];
    logic [31:0]     r_fetch_count;

    logic            w_advance;
    logic            w_accept;
    logic            w_handoff;
    logic [1:0]      w_fault;
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_rd_word;
    logic [XLEN-1:0] w_instr;

    assign rsp_valid   = r_vld_pipe[LAT];
    assign rsp_instr   = r_instr_pipe[LAT];
    assign rsp_pc      = r_pc_pipe[LAT];
    assign rsp_fault   = r_fault_pipe[LAT];
    assign fetch_count = r_fetch_count;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_advance = !rsp_valid || rsp_ready;
    assign req_ready = w_advance && !flush && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_handoff = rsp_valid && rsp_ready;

    // Out-of-range uses every upper PC bit so high addresses never alias into the array.
    assign w_fault[0] = |req_pc[1:0];
    assign w_fault[1] = |req_pc[XLEN-1:AW+2];
    assign w_idx      = req_pc[AW+1:2];
    assign w_rd_word  = r_mem[w_idx];
    assign w_instr    = (w_fault != 2'b00) ? NOP_WORD : w_rd_word;

    // Read-before-write: the read above sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (ld_we && !rst)
            r_mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe    <= '0;
            r_fetch_count <= '0;
            for (int s = 1; s <= LAT; s++) begin
                r_pc_pipe[s]    <= '0;
                r_instr_pipe[s] <= NOP_WORD;
                r_fault_pipe[s] <= '0;
            end
        end else if (flush) begin
            // Flush drops validity only; data fields stay put and nothing is counted.
            r_vld_pipe <= '0;
        end else if (w_advance) begin
            r_vld_pipe[1] <= w_accept;
            if (w_accept) begin
                r_pc_pipe[1]    <= req_pc;
                r_instr_pipe[1] <= w_instr;
                r_fault_pipe[1] <= w_fault;
            end
            for (int s = 2; s <= LAT; s++) begin
                r_vld_pipe[s]   <= r_vld_pipe[s-1];
                r_pc_pipe[s]    <= r_pc_pipe[s-1];
                r_instr_pipe[s] <= r_instr_pipe[s-1];
                r_fault_pipe[s] <= r_fault_pipe[s-1];
            end
            if (w_handoff)
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench: three instances (latency 1, 2, 3) share the stimulus; each scenario
// inspects the instance whose latency it targets.
module tb_instr_mem_pipe;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, req_valid, rsp_ready, flush, ld_we;
    logic [31:0] req_pc, ld_data;
    logic [7:0]  ld_addr;
    logic [3:1]  req_ready, rsp_valid;
    logic [31:0] rsp_instr   [1:3];
    logic [31:0] rsp_pc      [1:3];
    logic [31:0] fetch_count [1:3];
    logic [1:0]  rsp_fault   [1:3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar L = 1; L <= 3; L++) begin : g_dut
        instr_mem_pipe #(.READ_LATENCY(L)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid), .req_ready(req_ready[L]), .req_pc(req_pc),
            .flush(flush),
            .rsp_valid(rsp_valid[L]), .rsp_ready(rsp_ready),
            .rsp_instr(rsp_instr[L]), .rsp_pc(rsp_pc[L]), .rsp_fault(rsp_fault[L]),
            .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
            .fetch_count(fetch_count[L])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0; ld_we = 1'b0;
        repeat (5) tick();
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0; req_pc = '0;
        repeat (2) tick();
        for (int l = 1; l <= 3; l++) begin
            checks++;
            if ({req_ready[l], rsp_valid[l], rsp_instr[l], rsp_pc[l], rsp_fault[l], fetch_count[l]}
                !== {1'b0, 1'b0, NOP, 32'h0, 2'b00, 32'h0}) begin
                errors++;
                $display("FAIL reset_state lat%0d: rdy=%b vld=%b instr=%h pc=%h flt=%b cnt=%0d expected 0 0 %h 0 00 0",
                         l, req_ready[l], rsp_valid[l], rsp_instr[l], rsp_pc[l], rsp_fault[l], fetch_count[l], NOP);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b expected 1", req_ready[1]);
        end
    endtask

    task automatic test_basic;
        rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'h0;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid[1], rsp_instr[1], rsp_fault[1], rsp_pc[1]} !== {1'b1, NOP, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL basic_fetch: vld=%b instr=%h flt=%b pc=%h expected 1 %h 00 0",
                     rsp_valid[1], rsp_instr[1], rsp_fault[1], rsp_pc[1], NOP);
        end
        tick();
        checks++;
        if ({rsp_valid[1], fetch_count[1]} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL basic_handoff: vld=%b cnt=%0d expected 0 1", rsp_valid[1], fetch_count[1]);
        end
    endtask

    task automatic test_load;
        drain();
        load(8'd3, 32'h00500093);
        req_valid = 1'b1; req_pc = 32'hC;
        tick();
        checks++;
        if ({rsp_valid[1], rsp_instr[1], rsp_pc[1]} !== {1'b1, 32'h00500093, 32'hC}) begin
            errors++;
            $display("FAIL load_readback: vld=%b instr=%h pc=%h expected 1 00500093 0000000c",
                     rsp_valid[1], rsp_instr[1], rsp_pc[1]);
        end
        // Same-edge write to the word being fetched.
        ld_we = 1'b1; ld_addr = 8'd3; ld_data = 32'h00700093;
        tick();
        ld_we = 1'b0;
        checks++;
        if (rsp_instr[1] !== 32'h00500093) begin
            errors++; $display("FAIL collision_old_word: got %h expected 00500093", rsp_instr[1]);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_instr[1] !== 32'h00700093) begin
            errors++; $display("FAIL collision_new_word: got %h expected 00700093", rsp_instr[1]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pcs [4];
        logic [31:0] ins [4];
        logic [31:0] snap;
        logic        acc;
        int          nreq, nrsp;
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
        ins = '{NOP, 32'h00100113, 32'h00200193, 32'h00700093};
        load(8'd1, 32'h00100113);
        load(8'd2, 32'h00200193);
        drain();
        snap = fetch_count[3];
        nreq = 0; nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 4; c++) begin
            rsp_ready = (c >= 6);
            req_valid = (nreq < 4);
            req_pc    = pcs[nreq & 3];
            #1;
            acc = req_valid && req_ready[3];
            if (c == 4) begin
                checks++;
                if ({req_ready[3], nreq} !== {1'b0, 32'd3}) begin
                    errors++;
                    $display("FAIL stall_ready: rdy=%b accepted=%0d expected 0 3", req_ready[3], nreq);
                end
            end
            if (c == 5) begin
                checks++;
                if ({rsp_valid[3], rsp_pc[3]} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL stall_hold: vld=%b pc=%h expected 1 0", rsp_valid[3], rsp_pc[3]);
                end
            end
            if (rsp_valid[3] && rsp_ready) begin
                checks++;
                if ({rsp_pc[3], rsp_instr[3]} !== {pcs[nrsp & 3], ins[nrsp & 3]}) begin
                    errors++;
                    $display("FAIL b2b_order #%0d: pc=%h instr=%h expected %h %h",
                             nrsp, rsp_pc[3], rsp_instr[3], pcs[nrsp & 3], ins[nrsp & 3]);
                end
                nrsp++;
            end
            tick();
            if (acc) nreq++;
        end
        req_valid = 1'b0;
        checks++;
        if (nrsp != 4) begin
            errors++; $display("FAIL b2b_timeout: got %0d responses expected 4", nrsp);
        end
        checks++;
        if (fetch_count[3] - snap !== 32'd4) begin
            errors++; $display("FAIL b2b_count: got %0d expected 4", fetch_count[3] - snap);
        end
    endtask

    task automatic test_faults;
        logic [31:0] pcs [6];
        logic [1:0]  flt [6];
        drain();
        pcs = '{32'h2, 32'h400, 32'h401, 32'h40C, 32'hE, 32'h3FC};
        flt = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_pc = pcs[i];
            tick();
            checks++;
            if ({rsp_valid[1], rsp_fault[1], rsp_instr[1], rsp_pc[1]} !== {1'b1, flt[i], NOP, pcs[i]}) begin
                errors++;
                $display("FAIL fault pc=%h: vld=%b flt=%b instr=%h pc=%h expected 1 %b %h %h",
                         pcs[i], rsp_valid[1], rsp_fault[1], rsp_instr[1], rsp_pc[1], flt[i], NOP, pcs[i]);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_flush;
        logic [31:0] snap;
        int          seen;
        drain();
        snap = fetch_count[2];
        req_valid = 1'b1; req_pc = 32'h4;
        tick();
        req_pc = 32'h8;
        tick();
        flush = 1'b1; req_pc = 32'h10;
        #1;
        checks++;
        if (req_ready[2] !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b expected 0", req_ready[2]);
        end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        checks++;
        if ({rsp_valid[2], rsp_pc[2]} !== {1'b0, 32'h4}) begin
            errors++;
            $display("FAIL flush_clear: vld=%b pc=%h expected 0 00000004", rsp_valid[2], rsp_pc[2]);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid[2]) seen++;
            tick();
        end
        checks++;
        if ({seen, fetch_count[2]} !== {32'd0, snap}) begin
            errors++;
            $display("FAIL flush_drop: responses=%0d cnt=%0d expected 0 %0d", seen, fetch_count[2], snap);
        end
        req_valid = 1'b1; req_pc = 32'hC;
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if ({rsp_valid[2], rsp_instr[2], rsp_pc[2]} !== {1'b1, 32'h00700093, 32'hC}) begin
            errors++;
            $display("FAIL flush_recover: vld=%b instr=%h pc=%h expected 1 00700093 0000000c",
                     rsp_valid[2], rsp_instr[2], rsp_pc[2]);
        end
        tick();
        checks++;
        if (fetch_count[2] !== snap + 32'd1) begin
            errors++; $display("FAIL flush_count: got %0d expected %0d", fetch_count[2], snap + 32'd1);
        end
    endtask

    task automatic test_reset_mid;
        drain();
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h4;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid[1], rsp_instr[1]} !== {1'b1, 32'h00100113}) begin
            errors++;
            $display("FAIL mid_pre: vld=%b instr=%h expected 1 00100113", rsp_valid[1], rsp_instr[1]);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready[1], rsp_valid[1], rsp_instr[1], rsp_pc[1], rsp_fault[1], fetch_count[1]}
            !== {1'b0, 1'b0, NOP, 32'h0, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL mid_async_reset: rdy=%b vld=%b instr=%h pc=%h flt=%b cnt=%0d expected 0 0 %h 0 00 0",
                     req_ready[1], rsp_valid[1], rsp_instr[1], rsp_pc[1], rsp_fault[1], fetch_count[1], NOP);
        end
        // A load attempted under reset must not land.
        ld_we = 1'b1; ld_addr = 8'd1; ld_data = 32'hDEADBEEF;
        tick();
        ld_we = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_pc = 32'h4;
        tick();
        req_pc = 32'hC;
        checks++;
        if ({rsp_valid[1], rsp_instr[1]} !== {1'b1, 32'h00100113}) begin
            errors++;
            $display("FAIL mid_mem_kept_w1: vld=%b instr=%h expected 1 00100113", rsp_valid[1], rsp_instr[1]);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid[1], rsp_instr[1], fetch_count[1]} !== {1'b1, 32'h00700093, 32'd1}) begin
            errors++;
            $display("FAIL mid_mem_kept_w3: vld=%b instr=%h cnt=%0d expected 1 00700093 1",
                     rsp_valid[1], rsp_instr[1], fetch_count[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load();
        test_back_to_back();
        test_faults();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
